// File: rtl/cmos_pkg.sv
// rtl/cmos_pkg.sv - shared state encoding and frame geometry defaults for cmos_wr_ctrl
package cmos_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned H_ACT_DEF = 640;
  localparam int unsigned V_ACT_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_DONE     = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cmos_wr_ctrl.sv
// rtl/cmos_wr_ctrl.sv - frame-synchronised pixel writer from capture stage into a write FIFO
module cmos_wr_ctrl
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACT_DEF,
  parameter int unsigned V_ACT = V_ACT_DEF
) (
  input  logic                ov7670_pclk,
  input  logic                rst_n,
  input  logic [15:0]         pix_data,
  input  logic                pix_valid,
  input  logic                vsync_pos,
  input  logic                cap_en,
  input  logic                err_clr,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [15:0]         fifo_wr_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic [CNT_W-1:0]    pix_x,
  output logic [CNT_W-1:0]    pix_y,
  output logic                ovf_err,
  output logic                short_err,
  output logic                busy
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACT - 1);

  cap_state_t        state, state_nxt;
  logic              pix_ok;
  logic              accept;
  logic              drop;
  logic              last_pix;
  logic              restart;
  logic              short_set;
  logic [CNT_W-1:0]  x_nxt, y_nxt;

  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // vsync_pos takes priority over a coincident pixel while a frame is running
    pix_ok    = (state == ST_ACTIVE) && pix_valid && !vsync_pos;
    accept    = pix_ok && !fifo_full;
    drop      = pix_ok && fifo_full;
    last_pix  = pix_ok && (pix_x == X_LAST) && (pix_y == Y_LAST);
    restart   = vsync_pos && ((state == ST_WAIT_SOF) || (state == ST_ACTIVE));
    short_set = vsync_pos && (state == ST_ACTIVE);
    x_nxt     = pix_x;
    y_nxt     = pix_y;

    case (state)
      ST_IDLE:     if (cap_en) state_nxt = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (vsync_pos)    state_nxt = ST_ACTIVE;
        else if (!cap_en) state_nxt = ST_IDLE;
      end
      ST_ACTIVE:   if (last_pix) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = cap_en ? ST_WAIT_SOF : ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    if (restart) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (pix_ok) begin
      if (pix_x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (pix_y == Y_LAST) ? '0 : pix_y + CNT_W'(1);
      end else begin
        x_nxt = pix_x + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ov7670_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x        <= '0;
      pix_y        <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      ovf_err      <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      pix_x       <= x_nxt;
      pix_y       <= y_nxt;
      fifo_wr_en  <= accept;
      frame_start <= restart;
      frame_done  <= last_pix;
      if (accept) fifo_wr_data <= pix_data;
      // a new error event in the same cycle outranks the clear request
      if (drop)         ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (short_set)    short_err <= 1'b1;
      else if (err_clr) short_err <= 1'b0;
    end
  end

  assign busy = (state == ST_WAIT_SOF) || (state == ST_ACTIVE);

endmodule
